// File: rtl/cla_pkg.sv
// Shared constants, group-count helper and per-group P/G pair type
// for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CLA_DEFAULT_GROUP = 4;

  function automatic int unsigned cla_num_groups(input int unsigned width,
                                                 input int unsigned group);
    return width / group;
  endfunction

  typedef struct packed {
    logic gp;
    logic gg;
  } cla_pg_t;

endpackage

// File: rtl/cla_group_pg.sv
// One lookahead group: group propagate/generate from bit p/g, plus the
// carry into each bit of the group given the group carry-in.
module cla_group_pg
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = CLA_DEFAULT_GROUP
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             cin,
  output cla_pg_t          pg,
  output logic [GROUP-1:0] carry
);

  always_comb begin
    logic gg_acc;
    logic c;
    gg_acc = 1'b0;
    c      = cin;
    carry  = '0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      carry[i] = c;
      c        = g[i] | (p[i] & c);
      gg_acc   = g[i] | (p[i] & gg_acc);
    end
    pg.gp = &p;
    pg.gg = gg_acc;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
// Optional ovf/zero flag outputs are enabled by defining CLA_FLAGS_EN.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = CLA_DEFAULT_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int unsigned NG = cla_num_groups(WIDTH, GROUP);

  generate
    if ((WIDTH % GROUP) != 0 || !(GROUP == 2 || GROUP == 4 || GROUP == 8)) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and GROUP must be 2, 4 or 8");
    end
  endgenerate

  logic adv1, adv2, accept;
  logic s1_valid, s2_valid;

  assign adv2     = ~s2_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  assign in_ready = adv1;
  assign accept   = in_valid & adv1;

  // Stage 1: operand conditioning, bit and group P/G
  logic [WIDTH-1:0] bb, p_in, g_in;
  logic             c0_in;
  cla_pg_t          pg_in [NG];
  logic [WIDTH-1:0] s1_carry_unused;

  assign bb    = b ^ {WIDTH{sub}};
  assign p_in  = a ^ bb;
  assign g_in  = a & bb;
  assign c0_in = sub | cin;

  for (genvar k = 0; k < NG; k++) begin : g_s1
    cla_group_pg #(.GROUP(GROUP)) u_pg (
      .p     (p_in[k*GROUP +: GROUP]),
      .g     (g_in[k*GROUP +: GROUP]),
      .cin   (1'b0),
      .pg    (pg_in[k]),
      .carry (s1_carry_unused[k*GROUP +: GROUP])
    );
  end

  logic [WIDTH-1:0] p_q, g_q;
  logic             c0_q;
  cla_pg_t          pg_q [NG];

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (adv1) s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      p_q  <= p_in;
      g_q  <= g_in;
      c0_q <= c0_in;
      pg_q <= pg_in;
    end
  end

  // Stage 2: group carry chain, then in-group bit carries and sum
  logic [NG:0]      gc;
  logic [WIDTH-1:0] bit_c, sum_d;
  cla_pg_t          s2_pg_unused [NG];

  always_comb begin
    logic c;
    gc    = '0;
    c     = c0_q;
    gc[0] = c;
    for (int unsigned k = 0; k < NG; k++) begin
      c       = pg_q[k].gg | (pg_q[k].gp & c);
      gc[k+1] = c;
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_s2
    cla_group_pg #(.GROUP(GROUP)) u_pg (
      .p     (p_q[k*GROUP +: GROUP]),
      .g     (g_q[k*GROUP +: GROUP]),
      .cin   (gc[k]),
      .pg    (s2_pg_unused[k]),
      .carry (bit_c[k*GROUP +: GROUP])
    );
  end

  assign sum_d = p_q ^ bit_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
`ifdef CLA_FLAGS_EN
      ovf      <= 1'b0;
      zero     <= 1'b0;
`endif
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_d;
        cout <= gc[NG];
`ifdef CLA_FLAGS_EN
        ovf  <= bit_c[WIDTH-1] ^ gc[NG];
        zero <= ~|sum_d;
`endif
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench: WIDTH=32/GROUP=4 plus WIDTH=16 at GROUP=2 and GROUP=8,
// all driven in lockstep and checked against an arithmetic model.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] a, b;
  logic        cin, sub;
  logic [15:0] a16, b16;

  assign a16 = a[15:0];
  assign b16 = b[15:0];

  logic        rdy32, vld32, co32;
  logic [31:0] sum32;
  logic        rdyA, vldA, coA, rdyB, vldB, coB;
  logic [15:0] sumA, sumB;
`ifdef CLA_FLAGS_EN
  logic ovf32, zero32, ovfA, zeroA, ovfB, zeroB;
`endif

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(vld32), .out_ready(out_ready), .sum(sum32), .cout(co32)
`ifdef CLA_FLAGS_EN
    , .ovf(ovf32), .zero(zero32)
`endif
  );

  cla_pipe_adder #(.WIDTH(16), .GROUP(2)) dut16a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyA),
    .a(a16), .b(b16), .cin(cin), .sub(sub),
    .out_valid(vldA), .out_ready(out_ready), .sum(sumA), .cout(coA)
`ifdef CLA_FLAGS_EN
    , .ovf(ovfA), .zero(zeroA)
`endif
  );

  cla_pipe_adder #(.WIDTH(16), .GROUP(8)) dut16b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyB),
    .a(a16), .b(b16), .cin(cin), .sub(sub),
    .out_valid(vldB), .out_ready(out_ready), .sum(sumB), .cout(coB)
`ifdef CLA_FLAGS_EN
    , .ovf(ovfB), .zero(zeroB)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    int          acc;
  } op_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  op_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  int  pops   = 0;
  bit  armed  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain modular arithmetic: a + b + cin, or a + ~b + 1 for subtract.
  function automatic res_t model(input op_t o, input int w);
    longint unsigned mask, bb, c0, full, low, cm;
    res_t r;
    mask   = (64'd1 << w) - 64'd1;
    bb     = {32'd0, (o.sub ? ~o.b : o.b)} & mask;
    c0     = o.sub ? 64'd1 : {63'd0, o.cin};
    full   = ({32'd0, o.a} & mask) + bb + c0;
    low    = ({32'd0, o.a} & (mask >> 1)) + (bb & (mask >> 1)) + c0;
    cm     = (low >> (w - 1)) & 64'd1;
    r.sum  = 32'(full & mask);
    r.cout = full[w];
    r.ovf  = cm[0] ^ full[w];
    r.zero = ((full & mask) == 64'd0);
    return r;
  endfunction

  always @(negedge clk) begin
    bit   exp_ov, exp_rdy;
    res_t m32, m16;
    op_t  o;
    cyc++;
    if (rst) begin
      q.delete();
    end else if (armed) begin
      exp_rdy = !(q.size() == 2 && !out_ready);
      exp_ov  = (q.size() > 0) && (cyc >= q[0].acc + 2);
      chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
      chk("in_ready16g2", 64'(rdyA), 64'(exp_rdy));
      chk("in_ready16g8", 64'(rdyB), 64'(exp_rdy));
      chk("out_valid32", 64'(vld32), 64'(exp_ov));
      chk("out_valid16g2", 64'(vldA), 64'(exp_ov));
      chk("out_valid16g8", 64'(vldB), 64'(exp_ov));
      if (exp_ov) begin
        m32 = model(q[0], 32);
        m16 = model(q[0], 16);
        chk("sum32", 64'(sum32), 64'(m32.sum));
        chk("cout32", 64'(co32), 64'(m32.cout));
        chk("sum16g2", 64'(sumA), 64'(m16.sum));
        chk("cout16g2", 64'(coA), 64'(m16.cout));
        chk("sum16g8", 64'(sumB), 64'(m16.sum));
        chk("cout16g8", 64'(coB), 64'(m16.cout));
`ifdef CLA_FLAGS_EN
        chk("ovf32", 64'(ovf32), 64'(m32.ovf));
        chk("zero32", 64'(zero32), 64'(m32.zero));
        chk("ovf16g2", 64'(ovfA), 64'(m16.ovf));
        chk("zero16g2", 64'(zeroA), 64'(m16.zero));
        chk("ovf16g8", 64'(ovfB), 64'(m16.ovf));
        chk("zero16g8", 64'(zeroB), 64'(m16.zero));
`endif
        if (out_ready) begin
          void'(q.pop_front());
          pops++;
        end
      end
      if (in_valid && exp_rdy) begin
        o = '{a: a, b: b, cin: cin, sub: sub, acc: cyc};
        q.push_back(o);
      end
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv,
                      input logic ci, input logic sb);
    int n;
    n = 0;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    while (!rdy32 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rdy32) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic directed(input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic sb,
                          input logic [31:0] es, input logic ec,
                          input logic eo, input logic ez);
    send(av, bv, ci, sb);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_not_yet", 64'(vld32), 64'd0);
    @(negedge clk);
    chk("latency_two", 64'(vld32), 64'd1);
    chk("dir_sum", 64'(sum32), 64'(es));
    chk("dir_cout", 64'(co32), 64'(ec));
`ifdef CLA_FLAGS_EN
    chk("dir_ovf", 64'(ovf32), 64'(eo));
    chk("dir_zero", 64'(zero32), 64'(ez));
`else
    if (eo === 1'bx || ez === 1'bx) $display("note: flag expectation undefined");
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;

    @(negedge clk);
    chk("reset_in_ready", 64'(rdy32), 64'd1);
    chk("reset_out_valid", 64'(vld32), 64'd0);
    chk("reset_sum", 64'(sum32), 64'd0);
    chk("reset_cout", 64'(co32), 64'd0);
    @(posedge clk); #1;

    directed(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0);
    directed(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0);
    directed(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    chk("directed_pops", 64'(pops), 64'd7);

    // Streamed ops under a 1-0-0-1 out_ready pattern
    fork
      begin
        for (int i = 0; i < 10; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 48; i++) begin
          out_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("stream_drained", 64'(q.size()), 64'd0);
    chk("stream_pops", 64'(pops), 64'd17);

    // Reset with two operations in flight
    out_ready = 1'b0;
    send(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
    send(32'h0000_3333, 32'h0000_4444, 1'b1, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(vld32), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_result", 64'(vld32 | vldA | vldB), 64'd0);
    end
    chk("flush_pops", 64'(pops), 64'd17);

    @(posedge clk); #1;
    directed(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
